// File: rtl/sum_accumulator.sv
// sum_accumulator: collects COUNT_N adder results ({carry_out, sum_bytes})
// into an ACC_W-bit running total. The total, a sticky overflow flag and the
// sample count are handed to the consumer over a valid/ready handshake.
module sum_accumulator #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 16,
  parameter int COUNT_N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] sum_bytes,
  input  logic              carry_out,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_total,
  output logic              acc_overflow,
  output logic [7:0]        sample_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic               accept;
  logic               handoff;
  logic               last_sample;
  logic [ACC_W:0]     sample_ext;
  logic [ACC_W:0]     sum_ext;

  logic [ACC_W-1:0]   acc_d;
  logic               overflow_d;
  logic [7:0]         count_d;
  logic               valid_d;

  // The input side is open whenever no finished frame is waiting; it is a
  // pure state decode so upstream never sees a dependency on in_valid.
  assign in_ready    = !rst && (state_q != DONE);
  assign accept      = in_valid && in_ready && !clear;
  assign handoff     = (state_q == DONE) && out_ready;

  // The adder result is an unsigned (DATA_W+1)-bit value; the extra top bit
  // of the sum captures the carry out of the accumulator.
  assign sample_ext  = (ACC_W+1)'({carry_out, sum_bytes});
  assign sum_ext     = {1'b0, acc_total} + sample_ext;
  assign last_sample = (sample_count + 8'd1) == 8'(COUNT_N);

  // State register; reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear aborts the frame from any state.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            state_d = last_sample ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/datapath next values: zero on abort or handoff, add on accept,
  // otherwise hold (bubbles and a stalled DONE leave everything untouched).
  always_comb begin
    acc_d      = acc_total;
    overflow_d = acc_overflow;
    count_d    = sample_count;
    valid_d    = (state_d == DONE);
    if (clear || handoff) begin
      acc_d      = '0;
      overflow_d = 1'b0;
      count_d    = 8'd0;
    end else if (accept) begin
      acc_d      = sum_ext[ACC_W-1:0];
      overflow_d = acc_overflow | sum_ext[ACC_W];
      count_d    = sample_count + 8'd1;
    end
  end

  // Registered outputs; reset discards any partial or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_total    <= '0;
      acc_overflow <= 1'b0;
      sample_count <= 8'd0;
      out_valid    <= 1'b0;
    end else begin
      acc_total    <= acc_d;
      acc_overflow <= overflow_d;
      sample_count <= count_d;
      out_valid    <= valid_d;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: drives two accumulators (ACC_W=16 and ACC_W=10) with
// shared inputs and checks them against a frame-level integer model, a
// table of fixed vectors and a few hand-built corner sequences.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        carry_out = 1'b0;
  logic [7:0]  sum_bytes = 8'd0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_overflow;
  logic [15:0] a_acc;
  logic [7:0]  a_count;
  logic        b_in_ready, b_out_valid, b_overflow;
  logic [9:0]  b_acc;
  logic [7:0]  b_count;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: plain integer total of the frame's accepted samples.
  int    m_count = 0;
  longint m_total = 0;
  bit    m_done = 1'b0;

  typedef struct {
    bit       r;
    bit       cl;
    bit       v;
    bit       cy;
    bit [7:0] s;
    bit       ordy;
    bit       e_valid;
    int       e_acc;
    int       e_count;
    bit       e_ovf;
    bit       e_ready;
  } vec_t;

  vec_t vecs[18];

  sum_accumulator #(.DATA_W(8), .ACC_W(16), .COUNT_N(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .sum_bytes(sum_bytes), .carry_out(carry_out), .clear(clear),
    .out_valid(a_out_valid), .out_ready(out_ready), .acc_total(a_acc),
    .acc_overflow(a_overflow), .sample_count(a_count)
  );

  sum_accumulator #(.DATA_W(8), .ACC_W(10), .COUNT_N(4)) dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .sum_bytes(sum_bytes), .carry_out(carry_out), .clear(clear),
    .out_valid(b_out_valid), .out_ready(out_ready), .acc_total(b_acc),
    .acc_overflow(b_overflow), .sample_count(b_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Frame semantics straight from the behaviour description, per clock edge.
  task automatic modelStep();
    if (rst || clear) begin
      m_count = 0; m_total = 0; m_done = 1'b0;
    end else if (m_done) begin
      if (out_ready) begin
        m_count = 0; m_total = 0; m_done = 1'b0;
      end
    end else if (in_valid) begin
      m_total += longint'({carry_out, sum_bytes});
      m_count++;
      if (m_count == 4) m_done = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit r, input bit cl, input bit v, input bit cy,
                               input bit [7:0] s, input bit ordy);
    rst = r; clear = cl; in_valid = v; carry_out = cy; sum_bytes = s; out_ready = ordy;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " valid16"}, 32'(a_out_valid), 32'(m_done));
    check({tag, " acc16"},   32'(a_acc),       32'(m_total % 65536));
    check({tag, " ovf16"},   32'(a_overflow),  32'(m_total > 65535));
    check({tag, " count16"}, 32'(a_count),     32'(m_count));
    check({tag, " ready16"}, 32'(a_in_ready),  32'(!rst && !m_done));
    check({tag, " valid10"}, 32'(b_out_valid), 32'(m_done));
    check({tag, " acc10"},   32'(b_acc),       32'(m_total % 1024));
    check({tag, " ovf10"},   32'(b_overflow),  32'(m_total > 1023));
    check({tag, " count10"}, 32'(b_count),     32'(m_count));
    check({tag, " ready10"}, 32'(b_in_ready),  32'(!rst && !m_done));
  endtask

  initial begin
    // Fixed vectors: reset, basic frame, value-256 frame, stalled DONE.
    //           r cl v cy s      or  val acc   cnt ovf rdy
    vecs[0]  = '{1, 0, 0, 0, 8'd0,   0,  0,  0,    0,  0,  0};
    vecs[1]  = '{1, 0, 0, 0, 8'd0,   0,  0,  0,    0,  0,  0};
    vecs[2]  = '{0, 0, 1, 0, 8'd1,   0,  0,  1,    1,  0,  1};
    vecs[3]  = '{0, 0, 1, 0, 8'd1,   0,  0,  2,    2,  0,  1};
    vecs[4]  = '{0, 0, 1, 0, 8'd3,   0,  0,  5,    3,  0,  1};
    vecs[5]  = '{0, 0, 1, 0, 8'd255, 0,  1,  260,  4,  0,  0};
    vecs[6]  = '{0, 0, 0, 0, 8'd0,   1,  0,  0,    0,  0,  1};
    vecs[7]  = '{0, 0, 1, 1, 8'd0,   0,  0,  256,  1,  0,  1};
    vecs[8]  = '{0, 0, 1, 1, 8'd0,   0,  0,  512,  2,  0,  1};
    vecs[9]  = '{0, 0, 1, 1, 8'd0,   0,  0,  768,  3,  0,  1};
    vecs[10] = '{0, 0, 1, 1, 8'd0,   0,  1,  1024, 4,  0,  0};
    for (int i = 11; i < 16; i++)
      vecs[i] = '{0, 0, 1, 0, 8'd7,  0,  1,  1024, 4,  0,  0};
    vecs[16] = '{0, 0, 1, 0, 8'd7,   1,  0,  0,    0,  0,  1};
    vecs[17] = '{0, 0, 0, 0, 8'd0,   0,  0,  0,    0,  0,  1};

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].r, vecs[i].cl, vecs[i].v, vecs[i].cy, vecs[i].s, vecs[i].ordy);
      check($sformatf("vec%0d valid", i), 32'(a_out_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d acc", i),   32'(a_acc),       32'(vecs[i].e_acc));
      check($sformatf("vec%0d count", i), 32'(a_count),     32'(vecs[i].e_count));
      check($sformatf("vec%0d ovf", i),   32'(a_overflow),  32'(vecs[i].e_ovf));
      check($sformatf("vec%0d ready", i), 32'(a_in_ready),  32'(vecs[i].e_ready));
    end

    // Wrap and overflow: four samples of 511 exceed 2^10-1 but not 2^16-1.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 1, 8'hFF, 0);
      checkOutput("wrap");
    end
    check("wrap acc10", 32'(b_acc), 32'd1020);
    check("wrap ovf10", 32'(b_overflow), 32'd1);
    check("wrap acc16", 32'(a_acc), 32'd2044);
    check("wrap ovf16", 32'(a_overflow), 32'd0);
    applyStimulus(0, 0, 0, 0, 8'd0, 1);
    checkOutput("wrap handoff");
    check("wrap ovf10 cleared", 32'(b_overflow), 32'd0);

    // Bubbles between samples, then clear coinciding with a valid sample.
    applyStimulus(0, 0, 1, 0, 8'd10, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 8'd99, 0);
    applyStimulus(0, 0, 1, 0, 8'd20, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 8'd99, 0);
    checkOutput("bubble");
    check("bubble acc", 32'(a_acc), 32'd30);
    applyStimulus(0, 1, 1, 0, 8'd30, 0);
    check("clear acc", 32'(a_acc), 32'd0);
    check("clear count", 32'(a_count), 32'd0);
    for (int i = 5; i <= 8; i++) begin
      applyStimulus(0, 0, 1, 0, 8'(i), 0);
      applyStimulus(0, 0, 0, 0, 8'd0, 0);
    end
    checkOutput("after clear");
    check("after clear acc", 32'(a_acc), 32'd26);
    check("after clear valid", 32'(a_out_valid), 32'd1);
    // Clear in DONE with out_ready discards the result.
    applyStimulus(0, 1, 0, 0, 8'd0, 1);
    checkOutput("clear done");

    // Reset in ACCUM with count 3, and reset in DONE.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 8'd50, 0);
    check("pre-rst count", 32'(a_count), 32'd3);
    applyStimulus(1, 0, 1, 0, 8'd50, 0);
    checkOutput("rst accum");
    check("rst accum acc", 32'(a_acc), 32'd0);
    applyStimulus(0, 0, 0, 0, 8'd0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 8'd60, 0);
    check("pre-rst valid", 32'(a_out_valid), 32'd1);
    applyStimulus(1, 0, 0, 0, 8'd0, 1);
    checkOutput("rst done");
    check("rst done valid", 32'(a_out_valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 8'd0, 0);
    checkOutput("rst release");

    // Randomised traffic checked every cycle against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(99) < 2, $urandom_range(99) < 5,
                    $urandom_range(99) < 70, 1'($urandom_range(1)),
                    8'($urandom_range(255)), $urandom_range(99) < 50);
      checkOutput($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
